mfu_dot_seq: RTL and testbench

- Job sequencer for one multi-precision fused multiply unit (mFU).
- Accepts a dot-product job: precision mode plus vector length.
- Streams operand byte pairs into the mFU one per cycle and accumulates the signed 16-bit mFU products into a wide accumulator.
- Returns the sum on a valid/ready result port. It sits between the operand buffers and one systolic-array PE.

---
 rtl/mfu_dot_seq.sv | 141 ++++++++++++++
 tb/tb_mfu_dot_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfu_dot_seq.sv
// Dot-product job sequencer for one multi-precision fused multiply unit.
// Streams operand pairs into the mFU and sums its signed products into a wide accumulator.
module mfu_dot_seq #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [7:0]       mfu_a,
  output logic [7:0]       mfu_b,
  output logic [1:0]       mfu_mode,
  input  logic [15:0]      mfu_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [1:0] ModeNoop = 2'b11;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               pv_q;
  logic [7:0]         mfu_a_q, mfu_a_d;
  logic [7:0]         mfu_b_q, mfu_b_d;
  logic [1:0]         mfu_mode_q, mfu_mode_d;
  logic               cfg_err_q, cfg_err_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic               fire;
  logic               cfg_fire;
  logic [ACC_W-1:0]   p_ext;

  assign cfg_ready = (state_q == StIdle);
  assign op_ready  = (state_q == StRun);
  assign fire      = op_valid & op_ready;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign p_ext     = ACC_W'($signed(mfu_p));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    mfu_a_d     = mfu_a_q;
    mfu_b_d     = mfu_b_q;

    // pv marks that mfu_a/mfu_b hold a freshly accepted pair, so bubbles add nothing.
    if (pv_q) begin
      acc_d = acc_q + p_ext;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_valid && (cfg_mode != ModeNoop)) begin
          mode_d = cfg_mode;
          acc_d  = '0;
          if (cfg_len == '0) begin
            state_d = StDone;
          end else begin
            remaining_d = cfg_len;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (fire) begin
          mfu_a_d     = op_a;
          mfu_b_d     = op_b;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs follow the next state; the mFU idles on NOOP outside a job.
    mfu_mode_d  = ((state_d == StRun) || (state_d == StDrain)) ? mode_d : ModeNoop;
    res_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
    cfg_err_d   = cfg_fire && (cfg_mode == ModeNoop);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      remaining_q <= '0;
      acc_q       <= '0;
      pv_q        <= 1'b0;
      mfu_a_q     <= '0;
      mfu_b_q     <= '0;
      mfu_mode_q  <= ModeNoop;
      cfg_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      pv_q        <= fire;
      mfu_a_q     <= mfu_a_d;
      mfu_b_q     <= mfu_b_d;
      mfu_mode_q  <= mfu_mode_d;
      cfg_err_q   <= cfg_err_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign mfu_a     = mfu_a_q;
  assign mfu_b     = mfu_b_q;
  assign mfu_mode  = mfu_mode_q;
  assign cfg_err   = cfg_err_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mfu_dot_seq.sv
// Directed bench for mfu_dot_seq with a behavioural mFU (signed 8x8, 2x4x4 and 4x2x2 lane sums).
module tb_mfu_dot_seq;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             nrst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_err;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [7:0]       mfu_a;
  logic [7:0]       mfu_b;
  logic [1:0]       mfu_mode;
  logic [15:0]      mfu_p;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mfu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] m);
    int s;
    s = 0;
    case (m)
      2'b00: s = int'($signed(a)) * int'($signed(b));
      2'b01: for (int i = 0; i < 2; i++) begin
        s += int'($signed(a[i*4 +: 4])) * int'($signed(b[i*4 +: 4]));
      end
      2'b10: for (int i = 0; i < 4; i++) begin
        s += int'($signed(a[i*2 +: 2])) * int'($signed(b[i*2 +: 2]));
      end
      default: s = 0;
    endcase
    return s[15:0];
  endfunction

  assign mfu_p = mfu_model(mfu_a, mfu_b, mfu_mode);

  mfu_dot_seq #(
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_mode (cfg_mode),
    .cfg_len  (cfg_len),
    .cfg_err  (cfg_err),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .mfu_a    (mfu_a),
    .mfu_b    (mfu_b),
    .mfu_mode (mfu_mode),
    .mfu_p    (mfu_p),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a job; cfg inputs are scrambled afterwards to show they are not resampled.
  task automatic start_job(input string tag, input logic [1:0] m, input logic [LEN_W-1:0] len);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_len   = len;
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    cfg_mode  = 2'b11;
    cfg_len   = 16'h00ff;
  endtask

  task automatic send_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    check({tag, ".op_ready"}, 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    op_a     = 8'h5a;
    op_b     = 8'ha5;
  endtask

  task automatic take_result(input string tag, input logic [31:0] exp);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".res_data"}, res_data, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, ".res_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, ".idle"}, {30'd0, busy, cfg_ready}, 32'b01);
  endtask

  initial begin
    nrst      = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'b00;
    cfg_len   = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst.op_ready", 32'(op_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mfu_mode", 32'(mfu_mode), 32'd3);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.cfg_err", 32'(cfg_err), 32'd0);
    check("rst.mfu_ab", {16'd0, mfu_a, mfu_b}, 32'd0);
    nrst = 1'b1;
    tick();

    // Mode 00, three back-to-back pairs: 12 - 10 + 16129.
    start_job("m8", 2'b00, 16'd3);
    check("m8.busy", 32'(busy), 32'd1);
    check("m8.mfu_mode_run", 32'(mfu_mode), 32'd0);
    send_op("m8.p0", 8'h03, 8'h04);
    send_op("m8.p1", 8'hfe, 8'h05);
    send_op("m8.p2", 8'h7f, 8'h7f);
    check("m8.op_ready_drain", 32'(op_ready), 32'd0);
    check("m8.res_valid_t1", 32'(res_valid), 32'd0);
    tick();
    check("m8.mfu_mode_done", 32'(mfu_mode), 32'd3);
    take_result("m8", 32'h0000_3f03);

    // Mode 01, two 4x4 pairs: 11 + 47.
    start_job("m4", 2'b01, 16'd2);
    check("m4.mfu_mode_run", 32'(mfu_mode), 32'd1);
    send_op("m4.p0", 8'h12, 8'h34);
    send_op("m4.p1", 8'hf7, 8'h27);
    check("m4.mfu_mode_drain", 32'(mfu_mode), 32'd1);
    tick();
    check("m4.mfu_mode_done", 32'(mfu_mode), 32'd3);
    take_result("m4", 32'd58);

    // Mode 10, one 2x2 pair summing to -5.
    start_job("m2", 2'b10, 16'd1);
    send_op("m2.p0", 8'hd9, 8'h77);
    tick();
    take_result("m2", 32'hffff_fffb);

    // Illegal NOOP job is rejected with a one-cycle error pulse.
    cfg_valid = 1'b1;
    cfg_mode  = 2'b11;
    cfg_len   = 16'd5;
    tick();
    cfg_valid = 1'b0;
    check("noop.cfg_err", 32'(cfg_err), 32'd1);
    check("noop.busy", 32'(busy), 32'd0);
    check("noop.cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    check("noop.cfg_err_drop", 32'(cfg_err), 32'd0);
    check("noop.busy2", 32'(busy), 32'd0);

    // Zero-length job: result one cycle after accept.
    start_job("len0", 2'b00, 16'd0);
    take_result("len0", 32'd0);

    // Bubbles between pairs must not accumulate; result held under back-pressure.
    start_job("gap", 2'b00, 16'd4);
    send_op("gap.p0", 8'h01, 8'h01);
    send_op("gap.p1", 8'h01, 8'h01);
    tick();
    tick();
    send_op("gap.p2", 8'h01, 8'h01);
    tick();
    send_op("gap.p3", 8'h01, 8'h01);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("gap.hold_valid", 32'(res_valid), 32'd1);
      check("gap.hold_data", res_data, 32'd4);
      if (i == 2) begin
        cfg_valid = 1'b1;
        cfg_mode  = 2'b00;
        cfg_len   = 16'd1;
        check("gap.cfg_ready_done", 32'(cfg_ready), 32'd0);
      end
      tick();
      cfg_valid = 1'b0;
    end
    check("gap.busy_done", 32'(busy), 32'd1);
    take_result("gap", 32'd4);

    // Reset mid-job discards it; next job starts from a clean accumulator.
    start_job("rst", 2'b00, 16'd5);
    send_op("rst.p0", 8'h07, 8'h07);
    send_op("rst.p1", 8'h07, 8'h07);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("rst.mid_busy", 32'(busy), 32'd0);
    check("rst.mid_mode", 32'(mfu_mode), 32'd3);
    check("rst.mid_res_valid", 32'(res_valid), 32'd0);
    check("rst.mid_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    tick();
    check("rst.mid_res_valid2", 32'(res_valid), 32'd0);
    start_job("post", 2'b00, 16'd1);
    send_op("post.p0", 8'h02, 8'h03);
    tick();
    take_result("post", 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
